sc_div_sequencer: RTL and testbench

SC_DIV_SEQUENCER -- requirements
Module: sc_div_sequencer

---
 rtl/sc_ctrl_pkg.sv | 13 +
 rtl/sc_div_sequencer_len_timer.sv | 29 ++
 rtl/sc_div_sequencer.sv | 111 +++++++++++
 tb/tb_sc_div_sequencer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sc_ctrl_pkg.sv
// Shared control definitions for the stochastic division sequencer.
package sc_ctrl_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/sc_div_sequencer_len_timer.sv
// Bitstream length down-counter: reloads on load, counts down on enable,
// and flags the final cycle of the stream when the count is 1.
module len_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             last
);

  logic [WIDTH-1:0] count;

  // Cycle counter: load has priority over the decrement.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= count - 1'b1;
    end
  end

  assign last = (count == WIDTH'(1));

endmodule

// File: rtl/sc_div_sequencer.sv
// Sequencer for one stochastic-computing division run: reseeds the SNGs,
// runs them for N cycles while counting ones on the divider output stream,
// and publishes the count as the result.
module sc_div_sequencer
  import sc_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] stream_len,
  input  logic             bit_in,
  output logic             ready,
  output logic             busy,
  output logic             sng_load,
  output logic             sng_en,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_t           state;
  state_t           state_nx;
  logic             accept;
  logic             len_zero;
  logic             last;
  logic             run_finish;
  logic             zero_finish;
  logic [WIDTH-1:0] ones;

  assign accept      = (state == IDLE) && start && !abort;
  assign run_finish  = (state == RUN)  && !abort && last;
  assign zero_finish = (state == LOAD) && !abort && len_zero;

  len_timer #(.WIDTH(WIDTH)) u_len_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (stream_len),
    .en       (state == RUN),
    .last     (last)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; abort cancels LOAD/RUN but not DONE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = LOAD;
      LOAD: begin
        if (abort)         state_nx = IDLE;
        else if (len_zero) state_nx = DONE;
        else               state_nx = RUN;
      end
      RUN: begin
        if (abort)     state_nx = IDLE;
        else if (last) state_nx = DONE;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Remember whether the accepted length was zero so LOAD can skip RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      len_zero <= 1'b0;
    end else if (accept) begin
      len_zero <= (stream_len == '0);
    end
  end

  // Ones counter: cleared in LOAD, counts stream ones during RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      ones <= '0;
    end else if (state == LOAD) begin
      ones <= '0;
    end else if ((state == RUN) && bit_in) begin
      ones <= ones + 1'b1;
    end
  end

  // Result register, written only on entry to DONE; the last RUN bit is
  // folded in here because the ones counter has not absorbed it yet.
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
    end else if (run_finish) begin
      result <= ones + WIDTH'(bit_in);
    end else if (zero_finish) begin
      result <= '0;
    end
  end

  assign ready    = (state == IDLE);
  assign busy     = (state == LOAD) || (state == RUN);
  assign sng_load = (state == LOAD);
  assign sng_en   = (state == RUN);
  assign done     = (state == DONE);

endmodule

// File: tb/tb_sc_div_sequencer.sv
// Scoreboard bench for sc_div_sequencer: the driver pushes the expected
// outcome of each run, a monitor checks every done pulse against it.
module tb_sc_div_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         abort;
  logic [W-1:0] stream_len;
  logic         bit_in;
  logic         ready;
  logic         busy;
  logic         sng_load;
  logic         sng_en;
  logic         done;
  logic [W-1:0] result;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit mon_on   = 1'b0;

  typedef struct {
    int t;     // cycle index of the LOAD cycle
    int n;     // stream length
    int ones;  // ones presented during RUN
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   model_result = 0;
  int   load_cyc     = -1;
  int   en_cnt       = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sc_div_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .stream_len (stream_len),
    .bit_in     (bit_in),
    .ready      (ready),
    .busy       (busy),
    .sng_load   (sng_load),
    .sng_en     (sng_en),
    .done       (done),
    .result     (result)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: per-cycle state-decode sanity and scoreboard pop on done.
  always @(negedge clk) begin
    if (mon_on) begin
      chk("ready_only_idle", int'(ready), int'(!(busy || done)));
      if (sng_load) begin
        load_cyc = cyc;
        en_cnt   = 0;
      end
      if (sng_en) en_cnt++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e_m = sb.pop_front();
          chk("done_cycle", cyc, e_m.t + e_m.n + 1);
          chk("load_cycle", load_cyc, e_m.t);
          chk("sng_en_cycles", en_cnt, e_m.n);
          chk("result", int'(result), e_m.ones);
        end
      end
    end
  end

  // One run. Called at a negedge in an IDLE cycle; returns at a negedge in
  // an IDLE cycle. mode 0 random bits, 1 all ones, 2 bits from mask.
  // cut_at >= 0 interrupts the run in that RUN cycle with abort (or rst).
  task automatic run(input int n, input int mode, input logic [7:0] mask,
                     input int cut_at, input bit use_rst, input bit keep);
    logic b[$];
    int   ones = 0;
    int   t;
    for (int i = 0; i < n; i++) begin
      logic x;
      if (mode == 1)      x = 1'b1;
      else if (mode == 2) x = mask[3'(i % 8)];
      else                x = 1'($urandom_range(0, 1));
      b.push_back(x);
      ones += int'(x);
    end
    start      = 1'b1;
    abort      = 1'b0;
    stream_len = W'(n);
    @(negedge clk);
    t = cyc;
    if (!keep) start = 1'b0;
    if (cut_at < 0) begin
      sb.push_back('{t, n, ones});
      model_result = ones;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_in = b[i];
      if (i == cut_at) begin
        if (use_rst) begin
          rst = 1'b1;
        end else begin
          abort = 1'b1;
          start = 1'b1;
        end
        @(negedge clk);
        rst    = 1'b0;
        abort  = 1'b0;
        start  = 1'b0;
        bit_in = 1'b0;
        if (use_rst) model_result = 0;
        chk("cut_ready", int'(ready), 1);
        chk("cut_busy", int'(busy), 0);
        chk("cut_sng_en", int'(sng_en), 0);
        chk("cut_sng_load", int'(sng_load), 0);
        chk("cut_done", int'(done), 0);
        chk("cut_result", int'(result), model_result);
        @(negedge clk);
        chk("cut_start_not_queued", int'(ready), 1);
        chk("cut_result_held", int'(result), model_result);
        return;
      end
    end
    @(negedge clk);
    bit_in = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    bit_in     = 1'b0;
    stream_len = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_sng_load", int'(sng_load), 0);
    chk("rst_sng_en", int'(sng_en), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_result", int'(result), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", int'(ready), 1);
    chk("post_rst_busy", int'(busy), 0);
    chk("post_rst_done", int'(done), 0);
    mon_on = 1'b1;

    run(8, 2, 8'b0010_0101, -1, 1'b0, 1'b0);
    run(0, 0, 8'h00, -1, 1'b0, 1'b0);
    run(255, 1, 8'h00, -1, 1'b0, 1'b0);

    start      = 1'b1;
    abort      = 1'b1;
    stream_len = W'(5);
    @(negedge clk);
    chk("idle_abort_wins_ready", int'(ready), 1);
    chk("idle_abort_wins_load", int'(sng_load), 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_still_idle", int'(ready), 1);

    run(4, 0, 8'h00, -1, 1'b0, 1'b1);
    run(4, 0, 8'h00, -1, 1'b0, 1'b0);

    run(6, 1, 8'h00, -1, 1'b0, 1'b0);
    run(10, 0, 8'h00, 3, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      run($urandom_range(1, 24), 0, 8'h00, -1, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    run(9, 1, 8'h00, -1, 1'b0, 1'b0);
    run(12, 0, 8'h00, 5, 1'b1, 1'b0);
    @(negedge clk);
    chk("post_cut_rst_sng_en", int'(sng_en), 0);
    run(7, 0, 8'h00, -1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
